iobus_peripheral_hub: RTL and testbench

- Memory-mapped I/O responder on the far end of the MCU's IOBUS.
- Decodes IOBUS_ADDR/IOBUS_WR/IOBUS_OUT from the MEM stage and returns registered read data on IOBUS_IN.
- Provides switch input, LED output, a programmable down-counting timer, and the INTR line back into the core.
- Sits at top level beside the MCU; the MCU has no knowledge of peripheral internals.

---
 rtl/iobus_peripheral_hub.sv | 176 +++++++++++++++++
 tb/tb_iobus_peripheral_hub.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iobus_peripheral_hub.sv
// Memory-mapped IOBUS responder: synchronised switches, LED register and a
// programmable down-counting timer that raises INTR back into the core.
module iobus_peripheral_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          SW_WIDTH  = 16,
  parameter int          LED_WIDTH = 16,
  parameter int          PRESCALE  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INTR
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  localparam logic [2:0] REG_SW     = 3'd0;
  localparam logic [2:0] REG_LED    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_LOAD   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                ctrl_en;
  logic                ctrl_reload;
  logic                ctrl_irq_en;
  logic [31:0]         load_reg;
  logic [31:0]         count_reg;
  logic                pend;
  logic [PS_W-1:0]     prescale_cnt;

  logic        hit;
  logic [2:0]  reg_idx;
  logic        wr_led;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        tick;
  logic        expire;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign hit              = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign reg_idx          = IOBUS_ADDR[4:2];
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign wr_led    = IOBUS_WR && hit && (reg_idx == REG_LED);
  assign wr_ctrl   = IOBUS_WR && hit && (reg_idx == REG_CTRL);
  assign wr_load   = IOBUS_WR && hit && (reg_idx == REG_LOAD);
  assign wr_status = IOBUS_WR && hit && (reg_idx == REG_STATUS);

  assign tick   = ctrl_en && (prescale_cnt == PS_MAX);
  assign expire = tick && (count_reg == 32'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS <= '0;
    end else if (wr_led) begin
      LEDS <= IOBUS_OUT[LED_WIDTH-1:0];
    end
  end

  // A LOAD write restarts the prescale period so the first decrement is a full period away
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prescale_cnt <= '0;
    end else if (wr_load) begin
      prescale_cnt <= '0;
    end else if (ctrl_en) begin
      if (prescale_cnt == PS_MAX) begin
        prescale_cnt <= '0;
      end else begin
        prescale_cnt <= prescale_cnt + 1'b1;
      end
    end
  end

  // An explicit CTRL write wins over the one-shot auto-disable on expiry
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en     <= IOBUS_OUT[0];
      ctrl_reload <= IOBUS_OUT[1];
      ctrl_irq_en <= IOBUS_OUT[2];
    end else if (expire && !ctrl_reload) begin
      ctrl_en <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      load_reg <= '0;
    end else if (wr_load) begin
      load_reg <= IOBUS_OUT;
    end
  end

  // LOAD writes override any same-cycle decrement or reload
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_reg <= '0;
    end else if (wr_load) begin
      count_reg <= IOBUS_OUT;
    end else if (tick) begin
      if (count_reg != 32'd0) begin
        count_reg <= count_reg - 32'd1;
      end else if (ctrl_reload) begin
        count_reg <= load_reg;
      end
    end
  end

  // Expiry beats a same-cycle write-1-to-clear so no interrupt is lost
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= 1'b0;
    end else if (expire) begin
      pend <= 1'b1;
    end else if (wr_status && IOBUS_OUT[0]) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      INTR <= 1'b0;
    end else begin
      INTR <= pend && ctrl_irq_en;
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (reg_idx)
        REG_SW:     rd_data[SW_WIDTH-1:0]  = sw_sync;
        REG_LED:    rd_data[LED_WIDTH-1:0] = LEDS;
        REG_CTRL:   rd_data[2:0]           = {ctrl_irq_en, ctrl_reload, ctrl_en};
        REG_LOAD:   rd_data                = load_reg;
        REG_COUNT:  rd_data                = count_reg;
        REG_STATUS: rd_data[0]             = pend;
        default:    rd_data                = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IOBUS_IN <= '0;
    end else begin
      IOBUS_IN <= rd_data;
    end
  end

endmodule

// File: tb/tb_iobus_peripheral_hub.sv
// Directed bench for iobus_peripheral_hub: switches, LEDs, one-shot and
// periodic timer, W1C/expire collision, window misses and mid-count reset.
module tb_iobus_peripheral_hub;

  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LED    = 32'h1100_0004;
  localparam logic [31:0] A_CTRL   = 32'h1100_0008;
  localparam logic [31:0] A_LOAD   = 32'h1100_000C;
  localparam logic [31:0] A_COUNT  = 32'h1100_0010;
  localparam logic [31:0] A_STATUS = 32'h1100_0014;

  logic        CLK;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic        INTR;

  int checks;
  int failures;

  iobus_peripheral_hub dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .SWITCHES  (SWITCHES),
    .LEDS      (LEDS),
    .INTR      (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    IOBUS_WR   = wr;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    SWITCHES = 16'h0000;
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();
    step();
    check_output("reset_iobus_in", IOBUS_IN, 32'h0);
    check_output("reset_leds", {16'h0, LEDS}, 32'h0);
    check_output("reset_intr", {31'h0, INTR}, 32'h0);

    // switch path: two sync stages plus read register
    $display("[TB] switch synchroniser");
    RESET    = 1'b0;
    SWITCHES = 16'hA5A5;
    apply_stimulus(1'b0, A_SW, 32'h0);
    step();
    check_output("sw_edge1", IOBUS_IN, 32'h0);
    step();
    check_output("sw_edge2", IOBUS_IN, 32'h0);
    step();
    check_output("sw_edge3", IOBUS_IN, 32'h0000_A5A5);
    step();
    check_output("sw_edge4", IOBUS_IN, 32'h0000_A5A5);

    $display("[TB] LED register");
    apply_stimulus(1'b1, A_LED, 32'hFFFF_1234);
    step();
    check_output("led_write_leds", {16'h0, LEDS}, 32'h0000_1234);
    check_output("led_rw_same_cycle_old", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, A_LED, 32'h0);
    step();
    check_output("led_readback", IOBUS_IN, 32'h0000_1234);
    apply_stimulus(1'b1, A_SW, 32'h0000_0000);
    step();
    apply_stimulus(1'b0, A_SW, 32'h0);
    step();
    check_output("sw_ro_write_ignored", IOBUS_IN, 32'h0000_A5A5);

    $display("[TB] one-shot timer");
    apply_stimulus(1'b1, A_LOAD, 32'd3);
    step();
    apply_stimulus(1'b1, A_CTRL, 32'h5);
    step();
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("oneshot_count3", IOBUS_IN, 32'd3);
    step();
    check_output("oneshot_count2", IOBUS_IN, 32'd2);
    step();
    check_output("oneshot_count1", IOBUS_IN, 32'd1);
    apply_stimulus(1'b0, A_STATUS, 32'h0);
    step();
    check_output("oneshot_intr_not_yet", {31'h0, INTR}, 32'h0);
    step();
    check_output("oneshot_pend", IOBUS_IN, 32'h1);
    check_output("oneshot_intr", {31'h0, INTR}, 32'h1);
    apply_stimulus(1'b0, A_CTRL, 32'h0);
    step();
    check_output("oneshot_en_cleared", IOBUS_IN, 32'h4);
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("oneshot_count_held0", IOBUS_IN, 32'h0);

    $display("[TB] periodic timer");
    apply_stimulus(1'b1, A_STATUS, 32'h1);
    step();
    apply_stimulus(1'b1, A_LOAD, 32'd2);
    step();
    apply_stimulus(1'b1, A_CTRL, 32'h7);
    step();
    apply_stimulus(1'b0, A_STATUS, 32'h0);
    step();
    step();
    step();
    check_output("periodic_pend_lag", IOBUS_IN, 32'h0);
    check_output("periodic_intr_low", {31'h0, INTR}, 32'h0);
    step();
    check_output("periodic_pend_set", IOBUS_IN, 32'h1);
    check_output("periodic_intr_high", {31'h0, INTR}, 32'h1);
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("periodic_reloaded_count", IOBUS_IN, 32'd1);
    apply_stimulus(1'b1, A_STATUS, 32'h1);
    step();
    apply_stimulus(1'b0, A_STATUS, 32'h0);
    step();
    check_output("w1c_in_expire_keeps_pend", IOBUS_IN, 32'h1);
    check_output("w1c_in_expire_intr", {31'h0, INTR}, 32'h1);
    apply_stimulus(1'b1, A_STATUS, 32'h1);
    step();
    check_output("w1c_intr_lag", {31'h0, INTR}, 32'h1);
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("w1c_intr_dropped", {31'h0, INTR}, 32'h0);
    check_output("periodic_count_zero", IOBUS_IN, 32'h0);
    step();
    check_output("periodic_reexpire_intr", {31'h0, INTR}, 32'h1);
    apply_stimulus(1'b1, A_CTRL, 32'h0);
    step();
    apply_stimulus(1'b1, A_STATUS, 32'h1);
    step();

    $display("[TB] window misses and reserved slots");
    apply_stimulus(1'b1, 32'h1200_0004, 32'hDEAD_BEEF);
    step();
    check_output("miss_write_read0", IOBUS_IN, 32'h0);
    check_output("miss_write_leds", {16'h0, LEDS}, 32'h0000_1234);
    apply_stimulus(1'b1, 32'h1100_0018, 32'hFFFF_FFFF);
    step();
    check_output("reserved_write_read0", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, 32'h1100_001C, 32'h0);
    step();
    check_output("reserved_1c_read0", IOBUS_IN, 32'h0);
    apply_stimulus(1'b1, A_COUNT, 32'd55);
    step();
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("count_ro_write_ignored", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, A_LED, 32'h0);
    step();
    check_output("led_unchanged", IOBUS_IN, 32'h0000_1234);

    $display("[TB] reset mid-count");
    apply_stimulus(1'b1, A_LOAD, 32'd100);
    step();
    apply_stimulus(1'b1, A_CTRL, 32'h5);
    step();
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("midcount_count100", IOBUS_IN, 32'd100);
    step();
    check_output("midcount_count99", IOBUS_IN, 32'd99);
    RESET = 1'b1;
    apply_stimulus(1'b1, A_LED, 32'h0000_FFFF);
    step();
    RESET = 1'b0;
    check_output("rst_leds", {16'h0, LEDS}, 32'h0);
    check_output("rst_intr", {31'h0, INTR}, 32'h0);
    check_output("rst_iobus_in", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, A_COUNT, 32'h0);
    step();
    check_output("rst_count", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, A_CTRL, 32'h0);
    step();
    check_output("rst_ctrl", IOBUS_IN, 32'h0);
    apply_stimulus(1'b0, A_STATUS, 32'h0);
    for (int i = 0; i < 110; i++) begin
      step();
      check_output("rst_no_later_intr", {31'h0, INTR}, 32'h0);
    end
    check_output("rst_no_pend", IOBUS_IN, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
